// File: rtl/prog_fetch_unit_if.sv
`default_nettype none
// prog_fetch_unit_if: load, control and fetch-output bundle for prog_fetch_unit (rev 1.0).
// The breakpoint signals are present only when IFU_BREAKPOINT_EN is defined.
interface prog_fetch_unit_if #(
  parameter int IW = 8,
  parameter int PW = 8
);
  logic          ld_en;
  logic [PW-1:0] ld_addr;
  logic [IW-1:0] ld_data;
  logic          run;
  logic          stall;
  logic          br_take;
  logic [PW-1:0] br_target;
  logic [PW-1:0] PC;
  logic [PW-1:0] inst_pc;
  logic [IW-1:0] instruction;
  logic          inst_valid;
  logic [1:0]    state;
  logic          wrap;
  logic          err;
`ifdef IFU_BREAKPOINT_EN
  logic          bp_set;
  logic [PW-1:0] bp_addr;
  logic          bp_hit;
`endif

  modport master (
    output ld_en, ld_addr, ld_data, run, stall, br_take, br_target,
    input  PC, inst_pc, instruction, inst_valid, state, wrap, err
`ifdef IFU_BREAKPOINT_EN
    , output bp_set, bp_addr
    , input  bp_hit
`endif
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, run, stall, br_take, br_target,
    output PC, inst_pc, instruction, inst_valid, state, wrap, err
`ifdef IFU_BREAKPOINT_EN
    , input  bp_set, bp_addr
    , output bp_hit
`endif
  );
endinterface
`default_nettype wire

// File: rtl/prog_fetch_unit.sv
`default_nettype none
// prog_fetch_unit: program store + PC sequencer with stall, branch, wrap and halt/resume (rev 1.0).
// Define IFU_BREAKPOINT_EN to add a single armed PC breakpoint (bp_set/bp_addr/bp_hit).
module prog_fetch_unit #(
  parameter int IW     = 8,
  parameter int PW     = 8,
  parameter int DEPTH  = 256,
  parameter int RST_PC = 0
) (
  input  logic             _CLK,
  input  logic             RESET_N,
  prog_fetch_unit_if.slave fi
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [PW-1:0] PC_INIT = PW'(RST_PC);
  localparam logic [PW-1:0] PC_LAST = PW'(DEPTH - 1);

  logic [IW-1:0] mem [0:DEPTH-1];
  state_t        cur;
  logic [PW-1:0] pc_r;
  logic [PW-1:0] inst_pc_r;
  logic [IW-1:0] inst_r;
  logic          valid_r;
  logic          wrap_r;
  logic          err_r;
  logic          ld_ok;
  logic          br_bad;
  logic          bp_trig;

  assign ld_ok  = fi.ld_en && (cur != S_RUN) && (32'(fi.ld_addr) < 32'(DEPTH));
  assign br_bad = fi.br_take && (32'(fi.br_target) >= 32'(DEPTH));

  // Program store is intentionally left out of reset.
  always_ff @(posedge _CLK) begin
    if (ld_ok)
      mem[fi.ld_addr[AW-1:0]] <= fi.ld_data;
  end

`ifdef IFU_BREAKPOINT_EN
  logic [PW-1:0] bp_addr_r;
  logic          bp_armed;
  logic          bp_hit_r;
  logic          bp_skip;
  logic          fetch_go;

  // bp_skip lets the breakpoint word be fetched once after resuming from a breakpoint halt.
  assign bp_trig  = bp_armed && (pc_r == bp_addr_r) && !fi.stall && !bp_skip;
  assign fetch_go = (cur == S_RUN) && fi.run && !bp_trig && !fi.stall && !br_bad;

  always_ff @(posedge _CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bp_addr_r <= '0;
      bp_armed  <= 1'b0;
      bp_hit_r  <= 1'b0;
      bp_skip   <= 1'b0;
    end else begin
      if (fi.bp_set) begin
        bp_addr_r <= fi.bp_addr;
        bp_armed  <= 1'b1;
      end
      if ((cur == S_RUN) && fi.run && bp_trig) begin
        bp_hit_r <= 1'b1;
      end else if ((cur == S_HALT) && fi.run) begin
        bp_hit_r <= 1'b0;
        bp_skip  <= bp_hit_r;
      end else if (fetch_go) begin
        bp_skip  <= 1'b0;
      end
    end
  end

  assign fi.bp_hit = bp_hit_r;
`else
  assign bp_trig = 1'b0;
`endif

  always_ff @(posedge _CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur       <= S_IDLE;
      pc_r      <= PC_INIT;
      inst_pc_r <= '0;
      inst_r    <= '0;
      valid_r   <= 1'b0;
      wrap_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      case (cur)
        S_IDLE: begin
          if (fi.run) begin
            cur  <= S_RUN;
            pc_r <= PC_INIT;
          end
        end
        S_RUN: begin
          // Halt request outranks breakpoint, stall and branch.
          if (!fi.run || bp_trig) begin
            cur     <= S_HALT;
            valid_r <= 1'b0;
          end else if (!fi.stall) begin
            if (br_bad) begin
              err_r   <= 1'b1;
              cur     <= S_HALT;
              valid_r <= 1'b0;
            end else begin
              inst_r    <= mem[pc_r[AW-1:0]];
              inst_pc_r <= pc_r;
              valid_r   <= 1'b1;
              if (fi.br_take) begin
                pc_r <= fi.br_target;
              end else if (pc_r == PC_LAST) begin
                pc_r   <= '0;
                wrap_r <= 1'b1;
              end else begin
                pc_r <= pc_r + 1'b1;
              end
            end
          end
        end
        S_HALT: begin
          if (fi.run)
            cur <= S_RUN;
        end
        default: cur <= S_IDLE;
      endcase
    end
  end

  assign fi.PC          = pc_r;
  assign fi.inst_pc     = inst_pc_r;
  assign fi.instruction = inst_r;
  assign fi.inst_valid  = valid_r;
  assign fi.state       = cur;
  assign fi.wrap        = wrap_r;
  assign fi.err         = err_r;
endmodule
`default_nettype wire

// File: tb/tb_prog_fetch_unit.sv
`default_nettype none
// tb_prog_fetch_unit: directed stimulus with a queue scoreboard on the fetch output (rev 1.0).
// Breakpoint scenario is compiled in when IFU_BREAKPOINT_EN is defined.
module tb_prog_fetch_unit;
  localparam int IW     = 8;
  localparam int PW     = 8;
  localparam int DEPTH  = 4;
  localparam int RST_PC = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [PW+IW-1:0] exp_q [$];
  logic [PW+IW-1:0] exp_e;
  logic [IW-1:0]    prog [4];

  prog_fetch_unit_if #(.IW(IW), .PW(PW)) fi ();

  prog_fetch_unit #(
    .IW(IW), .PW(PW), .DEPTH(DEPTH), .RST_PC(RST_PC)
  ) dut (
    ._CLK   (clk),
    .RESET_N(rst_n),
    .fi     (fi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [PW-1:0] a, input logic [IW-1:0] d);
    exp_q.push_back({a, d});
    tick();
  endtask

  // Monitor: every presented valid word must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && fi.inst_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got pc=%0d inst=0x%0h expected none", fi.inst_pc, fi.instruction);
      end else begin
        exp_e = exp_q.pop_front();
        if ({fi.inst_pc, fi.instruction} !== exp_e) begin
          fails++;
          $display("FAIL sb_word: got pc=%0d inst=0x%0h expected pc=%0d inst=0x%0h",
                   fi.inst_pc, fi.instruction, exp_e[PW+IW-1:IW], exp_e[IW-1:0]);
        end
      end
    end
  end

  initial begin
    prog[0] = 8'h73; prog[1] = 8'h4D; prog[2] = 8'h74; prog[3] = 8'hB7;
    fi.ld_en = 1'b0; fi.ld_addr = '0; fi.ld_data = '0;
    fi.run = 1'b0; fi.stall = 1'b0; fi.br_take = 1'b0; fi.br_target = '0;
`ifdef IFU_BREAKPOINT_EN
    fi.bp_set = 1'b0; fi.bp_addr = '0;
`endif
    repeat (2) tick();
    chk("rst_pc",    int'(fi.PC), RST_PC);
    chk("rst_ipc",   int'(fi.inst_pc), 0);
    chk("rst_inst",  int'(fi.instruction), 0);
    chk("rst_valid", int'(fi.inst_valid), 0);
    chk("rst_state", int'(fi.state), 0);
    chk("rst_wrap",  int'(fi.wrap), 0);
    chk("rst_err",   int'(fi.err), 0);
    rst_n = 1'b1;

    // Load words 0..2, then load word 3 on the same edge as run.
    for (int i = 0; i < 4; i++) begin
      fi.ld_en = 1'b1; fi.ld_addr = PW'(i); fi.ld_data = prog[i];
      if (i == 3) fi.run = 1'b1;
      tick();
    end
    fi.ld_en = 1'b0;
    chk("go_state", int'(fi.state), 1);
    chk("go_pc",    int'(fi.PC), 0);
    chk("go_valid", int'(fi.inst_valid), 0);

    fetch(8'd0, 8'h73); chk("f0_pc", int'(fi.PC), 1);
    fetch(8'd1, 8'h4D); chk("f1_pc", int'(fi.PC), 2);
    fi.stall = 1'b1;
    fetch(8'd1, 8'h4D); chk("stall1_pc", int'(fi.PC), 2);
    fetch(8'd1, 8'h4D); chk("stall2_pc", int'(fi.PC), 2);
    fi.stall = 1'b0;
    fetch(8'd2, 8'h74); chk("f2_pc", int'(fi.PC), 3);

    fi.br_take = 1'b1; fi.br_target = 8'd0;
    fetch(8'd3, 8'hB7);
    chk("br_pc",   int'(fi.PC), 0);
    chk("br_wrap", int'(fi.wrap), 0);
    fi.br_take = 1'b0;
    fetch(8'd0, 8'h73);
    fetch(8'd1, 8'h4D);
    fetch(8'd2, 8'h74);
    fetch(8'd3, 8'hB7);
    chk("wrap_pulse", int'(fi.wrap), 1);
    chk("wrap_pc",    int'(fi.PC), 0);

    // Load attempt while running must not land.
    fi.ld_en = 1'b1; fi.ld_addr = 8'd0; fi.ld_data = 8'hFF;
    fetch(8'd0, 8'h73);
    chk("wrap_clear", int'(fi.wrap), 0);
    fi.ld_en = 1'b0;
    fetch(8'd1, 8'h4D);

    fi.br_take = 1'b1; fi.br_target = 8'd9;
    tick();
    chk("bad_err",   int'(fi.err), 1);
    chk("bad_state", int'(fi.state), 2);
    chk("bad_pc",    int'(fi.PC), 2);
    chk("bad_valid", int'(fi.inst_valid), 0);
    fi.br_take = 1'b0;
    tick();
    chk("resume_state", int'(fi.state), 1);
    chk("err_sticky",   int'(fi.err), 1);
    fetch(8'd2, 8'h74);

    fi.run = 1'b0; fi.br_take = 1'b1; fi.br_target = 8'd0;
    tick();
    chk("halt_state", int'(fi.state), 2);
    chk("halt_pc",    int'(fi.PC), 3);
    chk("halt_valid", int'(fi.inst_valid), 0);
    fi.br_take = 1'b0; fi.run = 1'b1;
    tick();
    chk("rerun_state", int'(fi.state), 1);
    fetch(8'd3, 8'hB7);
    fetch(8'd0, 8'h73);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(fi.state), 0);
    chk("arst_pc",    int'(fi.PC), RST_PC);
    chk("arst_valid", int'(fi.inst_valid), 0);
    fi.run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", int'(fi.state), 0);

`ifdef IFU_BREAKPOINT_EN
    fi.bp_set = 1'b1; fi.bp_addr = 8'd2;
    tick();
    fi.bp_set = 1'b0; fi.run = 1'b1;
    tick();
    fetch(8'd0, 8'h73);
    fetch(8'd1, 8'h4D);
    tick();
    chk("bp_state", int'(fi.state), 2);
    chk("bp_hit",   int'(fi.bp_hit), 1);
    chk("bp_pc",    int'(fi.PC), 2);
    chk("bp_valid", int'(fi.inst_valid), 0);
    tick();
    chk("bp_resume", int'(fi.state), 1);
    chk("bp_clear",  int'(fi.bp_hit), 0);
    fetch(8'd2, 8'h74);
    fetch(8'd3, 8'hB7);
    fetch(8'd0, 8'h73);
    fetch(8'd1, 8'h4D);
    tick();
    chk("bp2_state", int'(fi.state), 2);
    chk("bp2_hit",   int'(fi.bp_hit), 1);
    chk("bp2_pc",    int'(fi.PC), 2);
    fi.run = 1'b0;
`endif

    repeat (2) tick();
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
